// File: rtl/trigger_csr_ctrl.sv
// rtl/trigger_csr_ctrl.sv - CSR front end and hit/halt sequencer for a bank of sdtrig triggers
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   csr_addr/wdata/we/re  CSR file access (one strobe cycle per access)
//   csr_rdata, csr_rvalid registered read data, valid one cycle after csr_re
//   csr_sel               combinational: address lies in the trigger CSR window 0x7A0..0x7A4
//   tdata_wdata           write data broadcast to every trigger
//   tdata1/2/3_we         one-hot write enables, bit = currently selected trigger
//   tdata1/2/3_rd, tinfo_rd  packed per-trigger register values, slice i = trigger i
//   trig_hit, debug       per-trigger hit lines, core debug-mode flag
//   halt_req, halt_ack    halt handshake toward the debug controller
//   hit_index             lowest-numbered trigger that caused the current halt request

module trigger_csr_ctrl #(
   parameter int NTRIG = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [11:0]           csr_addr,
   input  logic [31:0]           csr_wdata,
   input  logic                  csr_we,
   input  logic                  csr_re,
   output logic [31:0]           csr_rdata,
   output logic                  csr_rvalid,
   output logic                  csr_sel,
   output logic [31:0]           tdata_wdata,
   output logic [NTRIG-1:0]      tdata1_we,
   output logic [NTRIG-1:0]      tdata2_we,
   output logic [NTRIG-1:0]      tdata3_we,
   input  logic [32*NTRIG-1:0]   tdata1_rd,
   input  logic [32*NTRIG-1:0]   tdata2_rd,
   input  logic [32*NTRIG-1:0]   tdata3_rd,
   input  logic [32*NTRIG-1:0]   tinfo_rd,
   input  logic [NTRIG-1:0]      trig_hit,
   input  logic                  debug,
   output logic                  halt_req,
   input  logic                  halt_ack,
   output logic [3:0]            hit_index
);

   localparam int SELW = (NTRIG > 1) ? $clog2(NTRIG) : 1;

   localparam logic [11:0] ADDR_TSELECT = 12'h7A0;
   localparam logic [11:0] ADDR_TDATA1  = 12'h7A1;
   localparam logic [11:0] ADDR_TDATA2  = 12'h7A2;
   localparam logic [11:0] ADDR_TDATA3  = 12'h7A3;
   localparam logic [11:0] ADDR_TINFO   = 12'h7A4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DBG  = 2'd2
   } state_e;

   state_e            state_q;
   logic [SELW-1:0]   tselect_q, tselect_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              rvalid_q;
   logic              halt_req_q;
   logic [3:0]        hit_index_q;

   logic [NTRIG-1:0]  sel_onehot;
   logic [31:0]       sel_tdata1, sel_tdata2, sel_tdata3, sel_tinfo;

   // Priority goes to the lowest-numbered trigger when several hit together.
   function automatic logic [3:0] lowest_set(input logic [NTRIG-1:0] v);
      logic [3:0] idx;
      idx = '0;
      for (int i = NTRIG - 1; i >= 0; i--) begin
         if (v[i]) idx = 4'(i);
      end
      return idx;
   endfunction

   assign csr_sel     = (csr_addr >= ADDR_TSELECT) && (csr_addr <= ADDR_TINFO);
   assign tdata_wdata = csr_wdata;

   always_comb begin
      for (int i = 0; i < NTRIG; i++) begin
         sel_onehot[i] = (tselect_q == SELW'(i));
      end
   end

   // Write steering always uses the tselect value held before this cycle's write.
   assign tdata1_we = (csr_we && csr_addr == ADDR_TDATA1) ? sel_onehot : '0;
   assign tdata2_we = (csr_we && csr_addr == ADDR_TDATA2) ? sel_onehot : '0;
   assign tdata3_we = (csr_we && csr_addr == ADDR_TDATA3) ? sel_onehot : '0;

   // Out-of-range tselect writes are dropped so tselect always names a real trigger.
   always_comb begin
      tselect_d = tselect_q;
      if (csr_we && csr_addr == ADDR_TSELECT && csr_wdata < 32'(NTRIG)) begin
         tselect_d = csr_wdata[SELW-1:0];
      end
   end

   // One-hot AND-OR mux of the selected trigger's registers.
   always_comb begin
      sel_tdata1 = '0;
      sel_tdata2 = '0;
      sel_tdata3 = '0;
      sel_tinfo  = '0;
      for (int i = 0; i < NTRIG; i++) begin
         if (sel_onehot[i]) begin
            sel_tdata1 = sel_tdata1 | tdata1_rd[32*i +: 32];
            sel_tdata2 = sel_tdata2 | tdata2_rd[32*i +: 32];
            sel_tdata3 = sel_tdata3 | tdata3_rd[32*i +: 32];
            sel_tinfo  = sel_tinfo  | tinfo_rd[32*i +: 32];
         end
      end
   end

   always_comb begin
      rdata_d = '0;
      case (csr_addr)
         ADDR_TSELECT: rdata_d = 32'(tselect_q);
         ADDR_TDATA1:  rdata_d = sel_tdata1;
         ADDR_TDATA2:  rdata_d = sel_tdata2;
         ADDR_TDATA3:  rdata_d = sel_tdata3;
         ADDR_TINFO:   rdata_d = sel_tinfo;
         default:      rdata_d = '0;
      endcase
   end

   // CSR state: read data is captured only on a read strobe and held otherwise.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tselect_q <= '0;
         rdata_q   <= '0;
         rvalid_q  <= 1'b0;
      end else begin
         tselect_q <= tselect_d;
         rvalid_q  <= csr_re;
         if (csr_re) rdata_q <= rdata_d;
      end
   end

   // Hit sequencer: hits are only taken in IDLE; REQ holds the request until
   // acked or debug is observed, DBG waits for the core to leave debug mode.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         halt_req_q  <= 1'b0;
         hit_index_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (|trig_hit && !debug) begin
                  hit_index_q <= lowest_set(trig_hit);
                  halt_req_q  <= 1'b1;
                  state_q     <= ST_REQ;
               end else if (debug) begin
                  state_q <= ST_DBG;
               end
            end
            ST_REQ: begin
               if (halt_ack || debug) begin
                  halt_req_q <= 1'b0;
                  state_q    <= ST_DBG;
               end
            end
            ST_DBG: begin
               if (!debug) state_q <= ST_IDLE;
            end
            default: begin
               halt_req_q <= 1'b0;
               state_q    <= ST_IDLE;
            end
         endcase
      end
   end

   assign csr_rdata  = rdata_q;
   assign csr_rvalid = rvalid_q;
   assign halt_req   = halt_req_q;
   assign hit_index  = hit_index_q;

endmodule
